// File: rtl/addr_mem_slave.sv
// addr_mem_slave
// Single-port, word-addressed register memory. It sits downstream of an
// en/wr/addr access stream. Reads return data after a fixed RD_LAT-cycle
// pipeline. A session is a contiguous run of en=1 cycles. An FSM tracks each
// session, waits for outstanding reads to drain when the session ends, and
// reports how many writes and reads the session performed.
//
// Ports:
//   clk         sole clock; all state updates on posedge
//   rst         synchronous, active-high reset; has priority over all inputs
//   en          access enable (only honoured in IDLE and ACTIVE)
//   wr          1 = write, 0 = read
//   addr        word address (ADDR_W bits)
//   wdata       write data (DATA_W bits)
//   rdata       read data; holds the last valid value while rvalid=0
//   rvalid      one-cycle pulse per accepted read
//   busy        high in ACTIVE and DRAIN
//   sess_done   one-cycle pulse when a session completes
//   sess_wr_cnt writes in the last completed session (saturating)
//   sess_rd_cnt reads in the last completed session (saturating)
module addr_mem_slave #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              sess_done,
  output logic [CNT_W-1:0]  sess_wr_cnt,
  output logic [CNT_W-1:0]  sess_rd_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [RD_LAT-1:0] pipe_v;
  logic [DATA_W-1:0] pipe_d [RD_LAT];

  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic [CNT_W-1:0] sess_wr_q, sess_rd_q;

  logic accept, acc_wr, acc_rd, in_flight;

  // Accesses are only taken while a session can still be counted. en during
  // DRAIN or DONE is ignored entirely.
  assign accept    = en && ((state == S_IDLE) || (state == S_ACTIVE));
  assign acc_wr    = accept && wr;
  assign acc_rd    = accept && !wr;
  assign in_flight = |pipe_v;

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  // NOTE: the memory is built from flops, so it can be cleared in a single
  // reset cycle. A RAM macro could not be reset this way.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (acc_wr) begin
      mem[addr] <= wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------
  // Stage 0 captures mem[addr] as it stood before the accepting edge. Each
  // data stage loads only when valid data arrives. Because of that, the last
  // stage naturally holds the last valid result between rvalid pulses.
  // NOTE: every sequential assignment here is non-blocking, so all stages
  // shift together on the same edge instead of racing through in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= acc_rd;
      if (acc_rd) pipe_d[0] <= mem[addr];
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign rvalid = pipe_v[RD_LAT-1];
  assign rdata  = pipe_d[RD_LAT-1];

  // ---------------------------------------------------------------------
  // Session FSM
  // ---------------------------------------------------------------------
  // NOTE: state_nxt gets its default before the case statement, so no path
  // through this block leaves it unassigned. That prevents an inferred latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (en) state_nxt = S_ACTIVE;
      S_ACTIVE: if (!en) state_nxt = in_flight ? S_DRAIN : S_DONE;
      S_DRAIN:  if (!in_flight) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      sess_wr_q <= '0;
      sess_rd_q <= '0;
    end else begin
      state <= state_nxt;

      unique case (state)
        // The first access of a session is counted on the same edge that
        // moves the FSM into ACTIVE.
        S_IDLE: begin
          wr_cnt <= CNT_W'(acc_wr);
          rd_cnt <= CNT_W'(acc_rd);
        end
        S_ACTIVE: begin
          if (acc_wr && (wr_cnt != CNT_MAX)) wr_cnt <= wr_cnt + 1'b1;
          if (acc_rd && (rd_cnt != CNT_MAX)) rd_cnt <= rd_cnt + 1'b1;
        end
        S_DONE: begin
          wr_cnt <= '0;
          rd_cnt <= '0;
        end
        default: ;
      endcase

      // Latch the results on entry to DONE, so they are already valid while
      // sess_done is high.
      if ((state_nxt == S_DONE) && (state != S_DONE)) begin
        sess_wr_q <= wr_cnt;
        sess_rd_q <= rd_cnt;
      end
    end
  end

  assign busy        = (state == S_ACTIVE) || (state == S_DRAIN);
  assign sess_done   = (state == S_DONE);
  assign sess_wr_cnt = sess_wr_q;
  assign sess_rd_cnt = sess_rd_q;

endmodule

// File: tb/tb_addr_mem_slave.sv
// Directed bench for addr_mem_slave.
// u_dut uses the default parameters (RD_LAT=2, CNT_W=8). u_sat shares the same
// stimulus but uses CNT_W=4, so counter saturation can be observed.
// Inputs change 1 ns after each rising edge, and outputs are sampled at that
// same point.
module tb_addr_mem_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       wr;
  logic [5:0] addr;
  logic [7:0] wdata;

  logic [7:0] rdata;
  logic       rvalid, busy, sess_done;
  logic [7:0] sess_wr_cnt, sess_rd_cnt;

  logic [7:0] s_rdata;
  logic       s_rvalid, s_busy, s_sess_done;
  logic [3:0] s_sess_wr_cnt, s_sess_rd_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int rv_seen;

  always #5 clk = ~clk;

  addr_mem_slave u_dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .busy(busy), .sess_done(sess_done),
    .sess_wr_cnt(sess_wr_cnt), .sess_rd_cnt(sess_rd_cnt)
  );

  addr_mem_slave #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(s_rdata), .rvalid(s_rvalid), .busy(s_busy), .sess_done(s_sess_done),
    .sess_wr_cnt(s_sess_wr_cnt), .sess_rd_cnt(s_sess_rd_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, pass the rising edge, then settle.
  task automatic cyc(input logic e, input logic w, input logic [5:0] a, input logic [7:0] d);
    en = e; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;

    // ---- reset: two cycles -> all outputs zero ----
    idle();
    idle();
    rst = 1'b0;
    check("rst_rdata",  rdata,       0);
    check("rst_rvalid", rvalid,      0);
    check("rst_busy",   busy,        0);
    check("rst_done",   sess_done,   0);
    check("rst_wrcnt",  sess_wr_cnt, 0);
    check("rst_rdcnt",  sess_rd_cnt, 0);

    // ---- read addr 5 after reset ----
    cyc(1'b1, 1'b0, 6'd5, 8'h00);        // edge A: IDLE->ACTIVE, read accepted
    check("rd5_rvalid_early", rvalid, 0);
    check("rd5_busy", busy, 1);
    idle();                               // edge A+1: ->DRAIN, result visible
    check("rd5_rvalid", rvalid, 1);
    check("rd5_rdata",  rdata,  8'h00);
    check("rd5_busy_drain", busy, 1);
    idle();                               // edge A+2: still draining
    check("rd5_rvalid_off", rvalid, 0);
    idle();                               // edge A+3: DONE
    check("rd5_done",  sess_done,   1);
    check("rd5_rdcnt", sess_rd_cnt, 1);
    check("rd5_wrcnt", sess_wr_cnt, 0);
    idle();
    check("rd5_done_off", sess_done, 0);

    // ---- waveform session: 8 writes then 8 reads of unwritten words ----
    rv_seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 4)       cyc(1'b1, 1'b1, 6'd12, 8'h4C);
      else if (i < 8)  cyc(1'b1, 1'b1, 6'd14, 8'h4E);
      else if (i < 12) cyc(1'b1, 1'b0, 6'd23, 8'h57);
      else             cyc(1'b1, 1'b0, 6'd48, 8'h70);
      check("wave_rvalid", rvalid, (i >= 9) ? 1 : 0);
      check("wave_busy", busy, 1);
      if (rvalid) begin
        rv_seen++;
        check("wave_rdata", rdata, 8'h00);
      end
    end
    idle();                               // en drops, last read still in flight
    check("wave_tail_rvalid", rvalid, 1);
    check("wave_tail_rdata",  rdata,  8'h00);
    if (rvalid) rv_seen++;
    check("wave_drain_busy", busy, 1);
    idle();                               // pipeline empties
    check("wave_drain_rvalid", rvalid, 0);
    check("wave_drain_nodone", sess_done, 0);
    idle();                               // DONE
    check("wave_done",   sess_done,   1);
    check("wave_wrcnt",  sess_wr_cnt, 8);
    check("wave_rdcnt",  sess_rd_cnt, 8);
    check("wave_done_busy", busy, 0);
    check("wave_sat_wrcnt", s_sess_wr_cnt, 8);
    check("wave_sat_rdcnt", s_sess_rd_cnt, 8);
    check("wave_pulses", rv_seen, 8);
    idle();
    check("wave_done_off", sess_done, 0);

    // ---- read back mem[12], mem[14]; rdata holds after the pulse ----
    cyc(1'b1, 1'b0, 6'd12, 8'h00);
    cyc(1'b1, 1'b0, 6'd14, 8'h00);
    check("mem12_rvalid", rvalid, 1);
    check("mem12", rdata, 8'h4C);
    idle();
    check("mem14", rdata, 8'h4E);
    idle();
    check("hold_rvalid", rvalid, 0);
    check("hold_rdata",  rdata,  8'h4E);
    idle();
    check("mem_rdcnt", sess_rd_cnt, 2);
    check("mem_wrcnt", sess_wr_cnt, 0);
    idle();

    // ---- write 63 at N, read 63 at N+1 ----
    cyc(1'b1, 1'b1, 6'd63, 8'hA5);        // edge N
    cyc(1'b1, 1'b0, 6'd63, 8'h00);        // edge N+1
    check("wtr_rvalid_early", rvalid, 0);
    idle();                               // edge N+2
    check("wtr_rvalid", rvalid, 1);
    check("wtr_rdata",  rdata,  8'hA5);
    idle();
    idle();
    check("wtr_done",  sess_done,   1);
    check("wtr_wrcnt", sess_wr_cnt, 1);
    check("wtr_rdcnt", sess_rd_cnt, 1);
    idle();

    // ---- drain with en pulsed during DRAIN ----
    cyc(1'b1, 1'b0, 6'd63, 8'h00);        // edge M: read accepted
    idle();                               // edge M+1: ->DRAIN
    check("drn_busy1",  busy,   1);
    check("drn_rvalid", rvalid, 1);
    check("drn_rdata",  rdata,  8'hA5);
    cyc(1'b1, 1'b1, 6'd0, 8'hFF);         // edge M+2: ignored write in DRAIN
    check("drn_busy2", busy, 1);
    idle();                               // edge M+3: DONE
    check("drn_done",  sess_done,   1);
    check("drn_rdcnt", sess_rd_cnt, 1);
    check("drn_wrcnt", sess_wr_cnt, 0);
    idle();
    cyc(1'b1, 1'b0, 6'd0, 8'h00);         // addr 0 must still be zero
    idle();
    check("drn_noaccess_rvalid", rvalid, 1);
    check("drn_noaccess", rdata, 8'h00);
    idle();
    idle();
    idle();

    // ---- reset while a read is in flight ----
    cyc(1'b1, 1'b0, 6'd12, 8'h00);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("rstd_rvalid", rvalid,      0);
    check("rstd_busy",   busy,        0);
    check("rstd_done",   sess_done,   0);
    check("rstd_rdcnt",  sess_rd_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("rstd_no_rvalid", rvalid,    0);
      check("rstd_no_done",   sess_done, 0);
      check("rstd_idle",      busy,      0);
    end

    // ---- saturation: 20 writes ----
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 6'(i), 8'(i));
    idle();                               // no reads in flight -> straight to DONE
    check("sat_done",       s_sess_done,   1);
    check("sat_wrcnt",      s_sess_wr_cnt, 15);
    check("sat_rdcnt",      s_sess_rd_cnt, 0);
    check("nosat_wrcnt",    sess_wr_cnt,   20);
    check("sat_busy",       s_busy,        0);
    idle();
    check("sat_done_off", s_sess_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
